// File: rtl/clock_ratio_monitor_if.sv
// Bus between a divided-clock source/controller and the ratio monitor:
// control and stimulus in, measurement and status out.
interface clock_ratio_monitor_if #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
);
  logic             enable;
  logic             div_clk_in;
  logic [CNT_W-1:0] exp_div;
  logic             clear_errors;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             locked;
  logic             error;
  logic             stall;
  logic [ERR_W-1:0] err_count;

  modport master (
    output enable, div_clk_in, exp_div, clear_errors,
    input  meas_valid, meas_period, meas_high, locked, error, stall, err_count
  );

  modport slave (
    input  enable, div_clk_in, exp_div, clear_errors,
    output meas_valid, meas_period, meas_high, locked, error, stall, err_count
  );
endinterface

// File: rtl/clock_ratio_monitor.sv
// Measures period and high time of a divided clock sampled in the fast domain
// and reports lock/mismatch/stall against an expected divide ratio.
module clock_ratio_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int ERR_W       = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  clock_ratio_monitor_if.slave bus
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] LOCK_V  = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] LOCK_M1 = RUN_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_MEASURE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync, w_sync_nxt;
  logic                   r_s_prev;
  logic                   w_s, w_rise;
  logic [CNT_W-1:0]       r_per_cnt, r_hi_cnt;
  logic [RUN_W-1:0]       r_run_cnt;
  logic                   r_meas_valid, r_locked, r_error, r_stall;
  logic [CNT_W-1:0]       r_meas_period, r_meas_high;
  logic [ERR_W-1:0]       r_err_cnt;
  logic                   w_quit, w_restart, w_count, w_capture, w_stall_evt;
  logic                   w_match, w_good, w_mismatch;

  generate
    if (SYNC_STAGES > 1) begin : g_chain
      assign w_sync_nxt = {r_sync[SYNC_STAGES-2:0], bus.div_clk_in};
    end else begin : g_single
      assign w_sync_nxt = bus.div_clk_in;
    end
  endgenerate

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync   <= '0;
      r_s_prev <= 1'b0;
      r_state  <= ST_IDLE;
    end else begin
      r_sync   <= w_sync_nxt;
      r_s_prev <= w_s;
      r_state  <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_quit      = 1'b0;
    w_restart   = 1'b0;
    w_count     = 1'b0;
    w_capture   = 1'b0;
    w_stall_evt = 1'b0;
    if (!bus.enable) begin
      w_state_nxt = ST_IDLE;
      w_quit      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (w_rise) begin
            w_restart   = 1'b1;
            w_state_nxt = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          // A rise landing exactly on the saturated count is still a valid period.
          if (w_rise) begin
            w_capture = 1'b1;
            w_restart = 1'b1;
          end else if (r_per_cnt == '1) begin
            w_stall_evt = 1'b1;
            w_state_nxt = ST_ACQUIRE;
          end else begin
            w_count = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_match = (bus.exp_div >= CNT_W'(2)) && (r_per_cnt == bus.exp_div) &&
                   (r_hi_cnt == bus.exp_div - (bus.exp_div >> 1));
  assign w_good     = w_capture & w_match;
  assign w_mismatch = w_capture & ~w_match;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
    end else if (w_restart) begin
      r_per_cnt <= CNT_W'(1);
      r_hi_cnt  <= CNT_W'(1);
    end else if (w_count) begin
      if (r_per_cnt != '1)          r_per_cnt <= r_per_cnt + CNT_W'(1);
      if (w_s && (r_hi_cnt != '1))  r_hi_cnt  <= r_hi_cnt + CNT_W'(1);
    end else if (w_state_nxt != ST_MEASURE) begin
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_meas_valid  <= 1'b0;
      r_meas_period <= '0;
      r_meas_high   <= '0;
      r_run_cnt     <= '0;
      r_locked      <= 1'b0;
      r_error       <= 1'b0;
      r_stall       <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_meas_valid <= w_capture;
      if (w_capture) begin
        r_meas_period <= r_per_cnt;
        r_meas_high   <= r_hi_cnt;
      end
      if (w_quit || w_stall_evt || w_mismatch) begin
        r_run_cnt <= '0;
        r_locked  <= 1'b0;
      end else if (w_good) begin
        if (r_run_cnt != LOCK_V) r_run_cnt <= r_run_cnt + RUN_W'(1);
        if (r_run_cnt >= LOCK_M1) r_locked <= 1'b1;
      end
      // New events override a simultaneous clear.
      if (bus.clear_errors) begin
        r_error   <= 1'b0;
        r_stall   <= 1'b0;
        r_err_cnt <= '0;
      end
      if (w_mismatch) begin
        r_error <= 1'b1;
        if (bus.clear_errors)      r_err_cnt <= ERR_W'(1);
        else if (r_err_cnt != '1)  r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
      if (w_stall_evt) r_stall <= 1'b1;
    end
  end

  assign bus.meas_valid  = r_meas_valid;
  assign bus.meas_period = r_meas_period;
  assign bus.meas_high   = r_meas_high;
  assign bus.locked      = r_locked;
  assign bus.error       = r_error;
  assign bus.stall       = r_stall;
  assign bus.err_count   = r_err_cnt;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Bench for clock_ratio_monitor: table of ratio scenarios, hand-written corner
// sequences and randomized waveforms, all checked against a cycle-stamp model.
module tb_clock_ratio_monitor;
  localparam int CNT_W  = 4;
  localparam int SYNC   = 2;
  localparam int LOCK   = 4;
  localparam int ERR_W  = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int ERRMAX = (1 << ERR_W) - 1;

  logic clock = 1'b0;
  logic reset;

  clock_ratio_monitor_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bif();

  clock_ratio_monitor #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .LOCK_COUNT(LOCK), .ERR_W(ERR_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int n_valid = 0;

  // Reference model: measurement = distance between rise timestamps and
  // number of high samples since the previous rise.
  bit  m_sync [SYNC];
  bit  m_prev;
  int  m_mode;      // 0 idle, 1 waiting for first edge, 2 measuring
  int  m_cyc;
  int  m_rise_cyc;
  int  m_highs;
  int  m_run;
  bit  e_valid, e_locked, e_error, e_stall;
  int  e_period, e_high, e_err;

  task automatic chk(input string nm, input logic [31:0] act, input int expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
    m_prev = 0; m_mode = 0; m_run = 0;
    e_valid = 0; e_locked = 0; e_error = 0; e_stall = 0;
    e_period = 0; e_high = 0; e_err = 0;
  endtask

  task automatic step();
    bit s, rise, match;
    int per, n;
    s = m_sync[SYNC-1];
    rise = s & ~m_prev;
    e_valid = 0;
    if (reset) begin
      model_reset();
    end else begin
      if (bif.clear_errors) begin e_error = 0; e_stall = 0; e_err = 0; end
      if (!bif.enable) begin
        m_mode = 0; e_locked = 0; m_run = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (rise) begin m_mode = 2; m_rise_cyc = m_cyc; m_highs = 1; end
      end else if (rise) begin
        per = m_cyc - m_rise_cyc;
        n = int'(bif.exp_div);
        e_valid = 1; e_period = per; e_high = m_highs;
        match = (n >= 2) && (per == n) && (m_highs == n - n / 2);
        if (match) begin
          if (m_run < LOCK) m_run++;
          e_locked = (m_run == LOCK);
        end else begin
          m_run = 0; e_locked = 0; e_error = 1;
          if (e_err < ERRMAX) e_err++;
        end
        m_rise_cyc = m_cyc; m_highs = 1;
      end else if (m_cyc - m_rise_cyc == CMAX) begin
        e_stall = 1; e_locked = 0; m_run = 0; m_mode = 1;
      end else begin
        m_highs += int'(s);
      end
      m_prev = s;
      for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = bif.div_clk_in;
    end
    m_cyc++;
    @(posedge clock);
    #1;
    if (bif.meas_valid === 1'b1) n_valid++;
    chk("meas_valid",  bif.meas_valid,  e_valid);
    chk("meas_period", bif.meas_period, e_period);
    chk("meas_high",   bif.meas_high,   e_high);
    chk("locked",      bif.locked,      e_locked);
    chk("error",       bif.error,       e_error);
    chk("stall",       bif.stall,       e_stall);
    chk("err_count",   bif.err_count,   e_err);
  endtask

  task automatic period(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      bif.div_clk_in = (i < h);
      step();
    end
  endtask

  task automatic fresh(input int n);
    bif.enable = 1'b0; bif.div_clk_in = 1'b0; bif.clear_errors = 1'b1;
    step();
    bif.clear_errors = 1'b0;
    step();
    bif.exp_div = CNT_W'(n);
    bif.enable = 1'b1;
    repeat (3) step();
  endtask

  typedef struct {
    int n; int p; int h; int reps;
    int x_per; int x_high; int x_lock; int x_error; int x_err;
  } vec_t;

  vec_t tbl [9];
  int nv0;

  initial begin
    tbl[0] = '{4,  4,  2, 5, 4,  2, 1, 0, 0};
    tbl[1] = '{3,  3,  2, 4, 3,  2, 1, 0, 0};
    tbl[2] = '{2,  3,  2, 3, 3,  2, 0, 1, 3};
    tbl[3] = '{5,  5,  3, 4, 5,  3, 1, 0, 0};
    tbl[4] = '{4,  4,  1, 4, 4,  1, 0, 1, 4};
    tbl[5] = '{1,  3,  2, 4, 3,  2, 0, 1, 4};
    tbl[6] = '{6,  6,  3, 4, 6,  3, 1, 0, 0};
    tbl[7] = '{15, 15, 8, 4, 15, 8, 1, 0, 0};
    tbl[8] = '{0,  3,  2, 8, 3,  2, 0, 1, 7};

    model_reset();
    m_cyc = 0;
    reset = 1'b1;
    bif.enable = 1'b0; bif.div_clk_in = 1'b0;
    bif.exp_div = '0; bif.clear_errors = 1'b0;
    repeat (3) step();
    chk("rst_locked", bif.locked, 0);
    chk("rst_err_count", bif.err_count, 0);
    chk("rst_meas_period", bif.meas_period, 0);
    reset = 1'b0;
    step();

    // Table: reps+1 periods yields reps visible measurements.
    for (int r = 0; r < 9; r++) begin
      fresh(tbl[r].n);
      repeat (tbl[r].reps + 1) period(tbl[r].p, tbl[r].h);
      chk("tbl_period", bif.meas_period, tbl[r].x_per);
      chk("tbl_high",   bif.meas_high,   tbl[r].x_high);
      chk("tbl_locked", bif.locked,      tbl[r].x_lock);
      chk("tbl_error",  bif.error,       tbl[r].x_error);
      chk("tbl_errcnt", bif.err_count,   tbl[r].x_err);
    end

    // One bad period while locked, then recovery.
    fresh(4);
    repeat (5) period(4, 2);
    chk("ml_locked_pre", bif.locked, 1);
    period(5, 2);
    period(4, 2);
    chk("ml_period", bif.meas_period, 5);
    chk("ml_locked", bif.locked, 0);
    chk("ml_errcnt", bif.err_count, 1);
    repeat (3) period(4, 2);
    chk("ml_relock_early", bif.locked, 0);
    period(4, 2);
    chk("ml_relock", bif.locked, 1);

    // Divided clock stops low while locked.
    bif.div_clk_in = 1'b0;
    repeat (22) step();
    chk("st_stall", bif.stall, 1);
    chk("st_locked", bif.locked, 0);
    chk("st_errcnt", bif.err_count, 1);
    nv0 = n_valid;
    period(5, 2);
    period(4, 2);
    chk("st_resume_cnt", n_valid - nv0, 1);
    chk("st_resume_per", bif.meas_period, 5);

    // Clear arriving on the same cycle as a mismatch capture.
    fresh(4);
    repeat (5) period(4, 2);
    period(5, 2);
    period(5, 2);
    for (int i = 0; i < 4; i++) begin
      bif.div_clk_in = (i < 2);
      bif.clear_errors = (i == 2);
      step();
    end
    bif.clear_errors = 1'b0;
    chk("cc_error", bif.error, 1);
    chk("cc_errcnt", bif.err_count, 1);
    for (int i = 0; i < 4; i++) begin
      bif.div_clk_in = (i < 2);
      bif.clear_errors = (i == 0);
      step();
    end
    bif.clear_errors = 1'b0;
    chk("cc_lone_error", bif.error, 0);
    chk("cc_lone_errcnt", bif.err_count, 0);

    // Reset asserted in the middle of a high phase.
    fresh(4);
    repeat (5) period(4, 2);
    bif.div_clk_in = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("rm_valid", bif.meas_valid, 0);
    chk("rm_locked", bif.locked, 0);
    chk("rm_period", bif.meas_period, 0);
    reset = 1'b0;
    bif.div_clk_in = 1'b0;
    repeat (2) step();
    nv0 = n_valid;
    period(4, 2);
    chk("rm_no_valid", n_valid - nv0, 0);
    period(4, 2);
    chk("rm_first_valid", n_valid - nv0, 1);

    // Randomized waveforms, ratios, enables, clears and resets.
    fresh(4);
    for (int b = 0; b < 40; b++) begin
      int p, h;
      if ($urandom_range(0, 9) == 0) p = $urandom_range(14, 20);
      else p = $urandom_range(3, 9);
      h = ($urandom_range(0, 9) < 7) ? (p - p / 2) : $urandom_range(1, p - 1);
      bif.exp_div = ($urandom_range(0, 9) < 7) ? CNT_W'(p) : CNT_W'($urandom_range(0, CMAX));
      for (int k = 0; k < 6; k++) begin
        for (int i = 0; i < p; i++) begin
          bif.div_clk_in   = (i < h);
          bif.clear_errors = ($urandom_range(0, 29) == 0);
          bif.enable       = ($urandom_range(0, 99) != 0);
          reset            = ($urandom_range(0, 299) == 0);
          step();
        end
      end
    end
    reset = 1'b0;
    bif.clear_errors = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
